uart_rx: RTL
============

Name: uart_rx

Overview:
- 16x-oversampling UART receiver; consumes the 16x tick produced by the team's baud generator (iTick16x, one iClk cycle wide).
- Format: 8N1 by default, LSB first, idle high.
- Sits between the board RX pin and the byte-stream consumer (command parser / FIFO).
- Delivers each received byte with a one-cycle valid strobe and flags framing errors.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..8).
- SYNC_STAGES, 2, flip-flop stages in the iRx synchronizer (>=2).
- PARITY_ODD, 0, parity sense when parity is compiled in (0 = even, 1 = odd).

Ports:
- iClk  input  1  system clock.
- iRst  input  1  reset, asynchronous, active-high.
- iTick16x  input  1  16x baud tick, one iClk cycle wide.
- iRx  input  1  asynchronous serial line, idle high.
- oData  output  DATA_BITS  last received byte; holds until the next frame completes.
- oValid  output  1  one-cycle strobe; oData is valid in the same cycle.
- oFrameErr  output  1  one-cycle strobe when the stop bit is sampled low.
- oParityErr  output  1  one-cycle strobe when parity mismatches; constant 0 without the macro.
- oBusy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values:
  - oData=0, oValid=0, oFrameErr=0, oParityErr=0, oBusy=0.
  - Synchronizer flops=1, FSM=IDLE, armed flag=1.
- iRx passes through SYNC_STAGES flops to give rxs. All FSM decisions happen only on iClk edges where iTick16x=1; with no tick, all state holds.
- A 4-bit tick counter cnt and a bit index idx control sampling.
- IDLE:
  - On a tick with rxs=1, set armed=1.
  - On a tick with rxs=0 and armed=1, go to START with cnt=0.
- START:
  - Increment cnt each tick.
  - At the tick where cnt==7 (mid start bit): if rxs=0, go to DATA with cnt=0, idx=0.
  - Otherwise (false start / glitch) return to IDLE with no strobes.
- DATA:
  - Increment cnt each tick, wrapping 15->0.
  - At cnt==15, shift rxs into the shift register MSB and right-shift (LSB first), then increment idx.
  - After DATA_BITS samples, go to PARITY if the macro is defined, else STOP.
- PARITY (macro only): at cnt==15, capture the parity bit, then go to STOP.
- STOP: at cnt==15, sample rxs, then go to IDLE.
  - rxs=1: oData <= shift register; oValid=1 for exactly one cycle (the cycle after the sampling edge); oParityErr is asserted in that same cycle if there was a mismatch.
  - rxs=0: oFrameErr=1 for one cycle; oValid=0; oData is not updated; armed=0, so no new frame starts until rxs is seen high on a tick (break handling).
- Latency from mid stop bit to oValid: 1 iClk.
- Timing: the start edge is detected within 1 tick plus synchronizer delay, so each data bit is sampled about 8 ticks after its nominal bit start (bit centre).
- oValid, oFrameErr and oParityErr are never asserted together, except oValid+oParityErr.
- iRst during any state returns the block to reset values at once. A partial frame is discarded with no strobe.
- A new start bit is accepted on the first tick after returning to IDLE, so back-to-back frames with a 1-bit stop work.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: a parity bit follows the data bits. Expected parity = XOR of data bits, XOR PARITY_ODD. A mismatch sets oParityErr alongside oValid; data is still delivered.
- Undefined: no PARITY state; frame is start + data + stop; oParityErr is tied to 0.

Decomposition:
- Package uart_pkg:
  - FSM state typedef (IDLE, START, DATA, PARITY, STOP).
  - OVERSAMPLE=16, MID_SAMPLE=7, LAST_SAMPLE=15.
  - Default DATA_BITS.
- Sub-module uart_rx_sync: SYNC_STAGES-deep synchronizer, reset to 1.
- The baud generator is instantiated by the parent, not inside this block.

Test Plan (the bench drives iTick16x every 4 iClk for speed; 1 bit = 16 ticks):
- Frame 0x55, stop=1 -> exactly one oValid pulse, oData=0x55, oFrameErr=0, oBusy low one cycle after the stop sample.
- Low glitch of 4 ticks on idle line -> START aborts at cnt==7, no strobe, oBusy returns 0, oData unchanged.
- Frame 0xA3 with stop=0, line then held low for 20 bit times -> one oFrameErr pulse, no oValid, oData unchanged, no further frame until the line goes high; then frame 0x12 -> oValid, oData=0x12.
- Back-to-back 0x00 then 0xFF, no idle gap -> two oValid pulses 160 ticks apart, oData=0x00 then 0xFF.
- iRst pulsed during DATA bit 4 of 0x3C -> all outputs 0, no strobe; a following frame 0x3C -> oValid, oData=0x3C.
- UART_RX_PARITY_EN defined, PARITY_ODD=0: frame 0x07 with parity bit 0 -> oValid=1, oParityErr=1, oData=0x07. Same frame with parity bit 1 -> oValid=1, oParityErr=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the 16x-oversampling UART receiver.
package uart_pkg;

    localparam int OVERSAMPLE        = 16;
    localparam int CNT_W             = $clog2(OVERSAMPLE);
    localparam int DEFAULT_DATA_BITS = 8;

    localparam logic [CNT_W-1:0] MID_SAMPLE  = CNT_W'(7);
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(15);

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-stage synchronizer for the asynchronous RX pin; resets to the idle (high) level.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic iClk,
    input  logic iRst,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] sync_reg;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
        end
    end

    assign dout = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver, 8N1 by default, LSB first.
// Define UART_RX_PARITY_EN to add a parity bit after the data bits.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = DEFAULT_DATA_BITS,
    parameter int SYNC_STAGES = 2,
    parameter int PARITY_ODD  = 0
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iTick16x,
    input  logic                 iRx,
    output logic [DATA_BITS-1:0] oData,
    output logic                 oValid,
    output logic                 oFrameErr,
    output logic                 oParityErr,
    output logic                 oBusy
);

    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 8 || SYNC_STAGES < 2 || PARITY_ODD < 0 || PARITY_ODD > 1)
    begin : g_param_check
        $error("uart_rx: parameter out of range");
    end

    logic                 rxs;
    state_t               state_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [2:0]           idx_reg;
    logic                 armed_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] data_reg;
    logic                 valid_reg;
    logic                 ferr_reg;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit_reg;
    logic                 perr_reg;
`endif

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .iClk (iClk),
        .iRst (iRst),
        .din  (iRx),
        .dout (rxs)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            armed_reg   <= 1'b1;
            shift_reg   <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            ferr_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_reg <= 1'b0;
            perr_reg    <= 1'b0;
`endif
        end else begin
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_reg  <= 1'b0;
`endif
            if (iTick16x) begin
                case (state_reg)
                    ST_IDLE: begin
                        // armed is cleared by a break so a held-low line cannot restart a frame
                        if (rxs) begin
                            armed_reg <= 1'b1;
                        end else if (armed_reg) begin
                            state_reg <= ST_START;
                            cnt_reg   <= '0;
                        end
                    end
                    ST_START: begin
                        if (cnt_reg == MID_SAMPLE) begin
                            if (!rxs) begin
                                state_reg <= ST_DATA;
                                cnt_reg   <= '0;
                                idx_reg   <= '0;
                            end else begin
                                state_reg <= ST_IDLE;
                            end
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == LAST_SAMPLE) begin
                            shift_reg <= {rxs, shift_reg[DATA_BITS-1:1]};
                            idx_reg   <= idx_reg + 1'b1;
                            if (idx_reg == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                                state_reg <= ST_PARITY;
`else
                                state_reg <= ST_STOP;
`endif
                            end
                        end
                    end
                    ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == LAST_SAMPLE) begin
                            par_bit_reg <= rxs;
                            state_reg   <= ST_STOP;
                        end
`else
                        state_reg <= ST_IDLE;
`endif
                    end
                    ST_STOP: begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == LAST_SAMPLE) begin
                            state_reg <= ST_IDLE;
                            if (rxs) begin
                                data_reg  <= shift_reg;
                                valid_reg <= 1'b1;
`ifdef UART_RX_PARITY_EN
                                perr_reg  <= (par_bit_reg != ((^shift_reg) ^ PARITY_ODD[0]));
`endif
                            end else begin
                                ferr_reg  <= 1'b1;
                                armed_reg <= 1'b0;
                            end
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign oData     = data_reg;
    assign oValid    = valid_reg;
    assign oFrameErr = ferr_reg;
    assign oBusy     = (state_reg != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign oParityErr = perr_reg;
`else
    assign oParityErr = 1'b0;
`endif

endmodule
